// File: rtl/mul_reservation_station.sv
// Collapsing, age-ordered reservation station feeding a single multiplier.
// Optional macro MUL_RS_CDB_FWD_EN: capture a same-cycle CDB broadcast into a dispatching entry.
module mul_reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_disp_valid,
    output logic                       o_disp_ready,
    input  logic [TAG_W-1:0]           i_disp_rob_tag,
    input  logic [1:0]                 i_disp_op,
    input  logic                       i_disp_src1_rdy,
    input  logic [31:0]                i_disp_src1_val,
    input  logic [TAG_W-1:0]           i_disp_src1_tag,
    input  logic                       i_disp_src2_rdy,
    input  logic [31:0]                i_disp_src2_val,
    input  logic [TAG_W-1:0]           i_disp_src2_tag,
    input  logic                       i_cdb_valid,
    input  logic [TAG_W-1:0]           i_cdb_tag,
    input  logic [31:0]                i_cdb_data,
    input  logic                       i_flush,
    output logic                       o_mul_valid,
    input  logic                       i_mul_ready,
    output logic [31:0]                o_mul_multiplier,
    output logic [31:0]                o_mul_multiplicand,
    output logic [TAG_W-1:0]           o_iss_rob_tag,
    output logic [1:0]                 o_iss_op,
    output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rob_tag;
        logic [1:0]       op;
        logic             s1_rdy;
        logic [TAG_W-1:0] s1_tag;
        logic [31:0]      s1_val;
        logic             s2_rdy;
        logic [TAG_W-1:0] s2_tag;
        logic [31:0]      s2_val;
    } entry_t;

    entry_t             r_entries [DEPTH];
    logic [CNT_W-1:0]   r_count;

    entry_t             w_woken   [DEPTH];
    entry_t             w_shifted [DEPTH];
    entry_t             w_nxt     [DEPTH];
    entry_t             w_new;
    logic [DEPTH-1:0]   w_rdy;
    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic               w_issue;
    logic               w_fire;
    logic [CNT_W-1:0]   w_tail;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_space;

    // Issue selection looks at registered state only, which gives the one-cycle minimum latency.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = r_entries[i].valid & r_entries[i].s1_rdy & r_entries[i].s2_rdy;
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_any = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
    end

    assign o_mul_valid        = w_any & ~i_flush;
    assign o_mul_multiplier   = r_entries[w_sel].s1_val;
    assign o_mul_multiplicand = r_entries[w_sel].s2_val;
    assign o_iss_rob_tag      = r_entries[w_sel].rob_tag;
    assign o_iss_op           = r_entries[w_sel].op;
    assign o_occupancy        = r_count;

    assign w_issue = o_mul_valid & i_mul_ready;
    assign w_space = (r_count < CNT_W'(DEPTH));

`ifdef MUL_RS_CDB_FWD_EN
    assign o_disp_ready = i_reset & w_space & ~i_flush;

    always_comb begin
        w_new.valid   = 1'b1;
        w_new.rob_tag = i_disp_rob_tag;
        w_new.op      = i_disp_op;
        w_new.s1_rdy  = i_disp_src1_rdy;
        w_new.s1_tag  = i_disp_src1_tag;
        w_new.s1_val  = i_disp_src1_val;
        w_new.s2_rdy  = i_disp_src2_rdy;
        w_new.s2_tag  = i_disp_src2_tag;
        w_new.s2_val  = i_disp_src2_val;
        if (i_cdb_valid && !i_disp_src1_rdy && (i_disp_src1_tag == i_cdb_tag)) begin
            w_new.s1_rdy = 1'b1;
            w_new.s1_val = i_cdb_data;
        end
        if (i_cdb_valid && !i_disp_src2_rdy && (i_disp_src2_tag == i_cdb_tag)) begin
            w_new.s2_rdy = 1'b1;
            w_new.s2_val = i_cdb_data;
        end
    end
`else
    logic w_cdb_hit;

    // Without forwarding, a broadcast the new entry would miss must stall dispatch instead.
    assign w_cdb_hit = i_cdb_valid &
                       ((~i_disp_src1_rdy & (i_disp_src1_tag == i_cdb_tag)) |
                        (~i_disp_src2_rdy & (i_disp_src2_tag == i_cdb_tag)));
    assign o_disp_ready = i_reset & w_space & ~i_flush & ~w_cdb_hit;

    always_comb begin
        w_new.valid   = 1'b1;
        w_new.rob_tag = i_disp_rob_tag;
        w_new.op      = i_disp_op;
        w_new.s1_rdy  = i_disp_src1_rdy;
        w_new.s1_tag  = i_disp_src1_tag;
        w_new.s1_val  = i_disp_src1_val;
        w_new.s2_rdy  = i_disp_src2_rdy;
        w_new.s2_tag  = i_disp_src2_tag;
        w_new.s2_val  = i_disp_src2_val;
    end
`endif

    assign w_fire      = i_disp_valid & o_disp_ready;
    assign w_tail      = r_count - CNT_W'(w_issue);
    assign w_count_nxt = i_flush ? '0 : (r_count + CNT_W'(w_fire) - CNT_W'(w_issue));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = r_entries[i];
            if (i_cdb_valid && r_entries[i].valid) begin
                if (!r_entries[i].s1_rdy && (r_entries[i].s1_tag == i_cdb_tag)) begin
                    w_woken[i].s1_rdy = 1'b1;
                    w_woken[i].s1_val = i_cdb_data;
                end
                if (!r_entries[i].s2_rdy && (r_entries[i].s2_tag == i_cdb_tag)) begin
                    w_woken[i].s2_rdy = 1'b1;
                    w_woken[i].s2_val = i_cdb_data;
                end
            end
        end
    end

    // Collapse over the issued slot, then append the dispatched entry at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_shifted[i] = w_woken[i];
        end
        if (w_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(w_sel)) begin
                    w_shifted[i] = w_woken[i+1];
                end
            end
            w_shifted[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = w_shifted[i];
            if (w_fire && (CNT_W'(i) == w_tail)) begin
                w_nxt[i] = w_new;
            end
            if (i_flush) begin
                w_nxt[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= w_nxt[i];
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_mul_reservation_station.sv
// Directed self-checking bench for mul_reservation_station (DEPTH 4, TAG_W 5).
module tb_mul_reservation_station;

    logic        clk;
    logic        reset;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_rob_tag;
    logic [1:0]  disp_op;
    logic        src1_rdy;
    logic [31:0] src1_val;
    logic [4:0]  src1_tag;
    logic        src2_rdy;
    logic [31:0] src2_val;
    logic [4:0]  src2_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic        mul_valid;
    logic        mul_ready;
    logic [31:0] mul_multiplier;
    logic [31:0] mul_multiplicand;
    logic [4:0]  iss_rob_tag;
    logic [1:0]  iss_op;
    logic [2:0]  occupancy;

    int n_checks;
    int n_errors;

    mul_reservation_station #(
        .DEPTH(4),
        .TAG_W(5)
    ) u_dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_disp_valid       (disp_valid),
        .o_disp_ready       (disp_ready),
        .i_disp_rob_tag     (disp_rob_tag),
        .i_disp_op          (disp_op),
        .i_disp_src1_rdy    (src1_rdy),
        .i_disp_src1_val    (src1_val),
        .i_disp_src1_tag    (src1_tag),
        .i_disp_src2_rdy    (src2_rdy),
        .i_disp_src2_val    (src2_val),
        .i_disp_src2_tag    (src2_tag),
        .i_cdb_valid        (cdb_valid),
        .i_cdb_tag          (cdb_tag),
        .i_cdb_data         (cdb_data),
        .i_flush            (flush),
        .o_mul_valid        (mul_valid),
        .i_mul_ready        (mul_ready),
        .o_mul_multiplier   (mul_multiplier),
        .o_mul_multiplicand (mul_multiplicand),
        .o_iss_rob_tag      (iss_rob_tag),
        .o_iss_op           (iss_op),
        .o_occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        disp_valid   = 1'b0;
        disp_rob_tag = '0;
        disp_op      = '0;
        src1_rdy     = 1'b0;
        src1_val     = '0;
        src1_tag     = '0;
        src2_rdy     = 1'b0;
        src2_val     = '0;
        src2_tag     = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
        flush        = 1'b0;
    endtask

    task automatic drive_disp(input logic [4:0] tag, input logic [1:0] op,
                              input logic r1, input logic [31:0] v1, input logic [4:0] t1,
                              input logic r2, input logic [31:0] v2, input logic [4:0] t2);
        disp_valid   = 1'b1;
        disp_rob_tag = tag;
        disp_op      = op;
        src1_rdy     = r1;
        src1_val     = v1;
        src1_tag     = t1;
        src2_rdy     = r2;
        src2_val     = v2;
        src2_tag     = t2;
    endtask

    // Inputs change at the falling edge; checks run 1 ns later, well away from the rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        mul_ready = 1'b0;
        drive_idle();

        // Reset state
        step(); #1;
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_mvalid", 32'(mul_valid), 32'd0);
        check_eq("rst_dready", 32'(disp_ready), 32'd0);
        step(); reset = 1'b1; #1;
        check_eq("rel_dready", 32'(disp_ready), 32'd1);

        // Single ready op: issues the cycle after dispatch
        step(); drive_disp(5'd3, 2'b11, 1'b1, 32'd7, 5'd0, 1'b1, 32'd6, 5'd0); mul_ready = 1'b1; #1;
        check_eq("t1_mvalid_same", 32'(mul_valid), 32'd0);
        step(); drive_idle(); #1;
        check_eq("t1_occ1", 32'(occupancy), 32'd1);
        check_eq("t1_mvalid", 32'(mul_valid), 32'd1);
        check_eq("t1_mplier", mul_multiplier, 32'd7);
        check_eq("t1_mcand", mul_multiplicand, 32'd6);
        check_eq("t1_tag", 32'(iss_rob_tag), 32'd3);
        check_eq("t1_op", 32'(iss_op), 32'd3);
        step(); #1;
        check_eq("t1_occ0", 32'(occupancy), 32'd0);
        check_eq("t1_mvalid0", 32'(mul_valid), 32'd0);

        // Wait on src1 tag 9, CDB broadcasts -7 two cycles later
        step(); drive_disp(5'd4, 2'b01, 1'b0, 32'd0, 5'd9, 1'b1, 32'd3, 5'd0); #1;
        step(); drive_idle(); #1;
        check_eq("t2_wait", 32'(mul_valid), 32'd0);
        step(); cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'hFFFF_FFF9; #1;
        check_eq("t2_cdb_cycle", 32'(mul_valid), 32'd0);
        step(); drive_idle(); #1;
        check_eq("t2_mvalid", 32'(mul_valid), 32'd1);
        check_eq("t2_mplier", mul_multiplier, 32'hFFFF_FFF9);
        check_eq("t2_mcand", mul_multiplicand, 32'd3);
        check_eq("t2_tag", 32'(iss_rob_tag), 32'd4);
        check_eq("t2_op", 32'(iss_op), 32'd1);
        step(); #1;
        check_eq("t2_occ0", 32'(occupancy), 32'd0);

        // Fill, then drain in dispatch order
        mul_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); drive_disp(5'(k), 2'b00, 1'b1, 32'(10 + k), 5'd0, 1'b1, 32'd1, 5'd0); #1;
        end
        step(); drive_disp(5'd15, 2'b00, 1'b1, 32'd99, 5'd0, 1'b1, 32'd1, 5'd0);
        mul_ready = 1'b1; #1;
        check_eq("t3_full_occ", 32'(occupancy), 32'd4);
        check_eq("t3_full_dready", 32'(disp_ready), 32'd0);
        check_eq("t3_tag0", 32'(iss_rob_tag), 32'd0);
        check_eq("t3_mplier0", mul_multiplier, 32'd10);
        for (int k = 1; k < 4; k++) begin
            step(); drive_idle(); #1;
            check_eq("t3_mvalid", 32'(mul_valid), 32'd1);
            check_eq("t3_occ", 32'(occupancy), 32'(4 - k));
            check_eq("t3_tag", 32'(iss_rob_tag), 32'(k));
            check_eq("t3_mplier", mul_multiplier, 32'(10 + k));
        end
        step(); #1;
        check_eq("t3_occ0", 32'(occupancy), 32'd0);
        check_eq("t3_mvalid0", 32'(mul_valid), 32'd0);

        // Older waiting A, younger ready B: B first, then A once woken
        mul_ready = 1'b0;
        step(); drive_disp(5'd10, 2'b10, 1'b0, 32'd0, 5'd20, 1'b1, 32'd2, 5'd0); #1;
        step(); drive_disp(5'd11, 2'b00, 1'b1, 32'd5, 5'd0, 1'b1, 32'd6, 5'd0); #1;
        step(); drive_idle(); #1;
        check_eq("t4_b_tag", 32'(iss_rob_tag), 32'd11);
        check_eq("t4_b_mplier", mul_multiplier, 32'd5);
        mul_ready = 1'b1;
        step(); cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_data = 32'd9; #1;
        check_eq("t4_no_dup", 32'(mul_valid), 32'd0);
        check_eq("t4_occ1", 32'(occupancy), 32'd1);
        step(); drive_idle(); #1;
        check_eq("t4_a_mvalid", 32'(mul_valid), 32'd1);
        check_eq("t4_a_tag", 32'(iss_rob_tag), 32'd10);
        check_eq("t4_a_mplier", mul_multiplier, 32'd9);
        check_eq("t4_a_mcand", mul_multiplicand, 32'd2);
        step(); #1;
        check_eq("t4_done", 32'(mul_valid), 32'd0);
        check_eq("t4_occ0", 32'(occupancy), 32'd0);

        // Flush with three entries and a concurrent dispatch
        mul_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); drive_disp(5'(20 + k), 2'b00, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0); #1;
        end
        step(); drive_disp(5'd30, 2'b00, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0); flush = 1'b1; #1;
        check_eq("t5_flush_mvalid", 32'(mul_valid), 32'd0);
        check_eq("t5_flush_dready", 32'(disp_ready), 32'd0);
        step(); drive_idle(); mul_ready = 1'b1; #1;
        check_eq("t5_occ0", 32'(occupancy), 32'd0);
        check_eq("t5_mvalid0", 32'(mul_valid), 32'd0);
        step(); #1;
        check_eq("t5_still0", 32'(mul_valid), 32'd0);

        // Dispatch racing a CDB broadcast on src2 tag 5
        mul_ready = 1'b0;
        step(); drive_disp(5'd12, 2'b00, 1'b1, 32'd4, 5'd0, 1'b0, 32'd0, 5'd5);
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'd8; #1;
`ifdef MUL_RS_CDB_FWD_EN
        check_eq("t6_fwd_dready", 32'(disp_ready), 32'd1);
        step(); drive_idle(); #1;
`else
        check_eq("t6_stall_dready", 32'(disp_ready), 32'd0);
        step(); drive_idle(); drive_disp(5'd12, 2'b00, 1'b1, 32'd4, 5'd0, 1'b1, 32'd8, 5'd0); #1;
        check_eq("t6_retry_dready", 32'(disp_ready), 32'd1);
        check_eq("t6_retry_occ0", 32'(occupancy), 32'd0);
        step(); drive_idle(); #1;
`endif
        check_eq("t6_mvalid", 32'(mul_valid), 32'd1);
        check_eq("t6_tag", 32'(iss_rob_tag), 32'd12);
        check_eq("t6_mplier", mul_multiplier, 32'd4);
        check_eq("t6_mcand", mul_multiplicand, 32'd8);
        mul_ready = 1'b1;
        step(); #1;
        check_eq("t6_occ0", 32'(occupancy), 32'd0);

        // Reset mid-operation discards entries, including a partially woken one
        mul_ready = 1'b0;
        step(); drive_disp(5'd2, 2'b00, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0); #1;
        step(); drive_disp(5'd6, 2'b00, 1'b0, 32'd0, 5'd7, 1'b0, 32'd0, 5'd8); #1;
        step(); drive_idle(); cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'd3; #1;
        step(); drive_idle(); reset = 1'b0; #1;
        check_eq("t7_rst_occ", 32'(occupancy), 32'd0);
        check_eq("t7_rst_mvalid", 32'(mul_valid), 32'd0);
        check_eq("t7_rst_dready", 32'(disp_ready), 32'd0);
        step(); reset = 1'b1; mul_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd8; #1;
        check_eq("t7_rel_mvalid", 32'(mul_valid), 32'd0);
        step(); drive_idle(); #1;
        check_eq("t7_no_residual", 32'(mul_valid), 32'd0);
        check_eq("t7_occ0", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_reservation_station.md
MUL_RESERVATION_STATION -- requirements
Module: mul_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..8).
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have dispatch ports: disp_valid in 1; disp_ready out 1; disp_rob_tag in TAG_W; disp_op in 2 (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU, carried unchanged).
REQ-006 SHALL have operand ports, each in: disp_src1_rdy 1; disp_src1_val 32; disp_src1_tag TAG_W; disp_src2_rdy 1; disp_src2_val 32; disp_src2_tag TAG_W.
REQ-007 SHALL have CDB ports, each in: cdb_valid 1; cdb_tag TAG_W; cdb_data 32.
REQ-008 SHALL have flush  in  1  squash all entries.
REQ-009 SHALL have multiplier-side ports: mul_valid out 1 (to multiplier valid_in); mul_ready in 1 (from multiplier ready); mul_multiplier out 32 (src1); mul_multiplicand out 32 (src2); iss_rob_tag out TAG_W; iss_op out 2.
REQ-010 SHALL have occupancy  out  $clog2(DEPTH+1)  count of valid entries.

Function
REQ-011 SHALL hold entries as a collapsing age-ordered queue; slot 0 oldest; each entry holds valid, rob_tag, op, and per operand {rdy, tag, val}.
REQ-012 SHALL assert disp_ready when occupancy < DEPTH and flush = 0; dispatch fires on disp_valid & disp_ready.
REQ-013 SHALL write a dispatched entry at the tail in the fire edge, after any same-edge issue collapse.
REQ-014 SHALL, on cdb_valid, for every valid entry operand with rdy = 0 and tag == cdb_tag, set rdy = 1 and val = cdb_data at that edge; both operands of one entry may wake in the same edge.
REQ-015 SHALL drive mul_valid combinationally from registered state only: 1 iff some valid entry has both operands rdy and flush = 0.
REQ-016 SHALL present the oldest fully-ready entry on mul_multiplier, mul_multiplicand, iss_rob_tag and iss_op while mul_valid = 1.
REQ-017 SHALL remove the presented entry on mul_valid & mul_ready, shifting younger entries down one slot at that edge.
REQ-018 SHALL apply minimum latency of one cycle: an entry dispatched fully ready at edge N issues no earlier than edge N+1; a CDB wakeup at edge N permits issue at edge N+1.
REQ-019 SHALL keep mul_valid and presented data stable until accepted, unless a strictly older entry becomes ready, which then takes priority.
REQ-020 SHALL support simultaneous dispatch, issue and wakeup in one edge, with occupancy changing by (+dispatch - issue).
REQ-021 SHALL, when full with issue firing, still hold disp_ready = 0 in that cycle.
REQ-022 SHALL, on flush = 1, clear all valid bits at the edge, ignore dispatch, and force mul_valid = 0 in that cycle; an operation already accepted by the multiplier is not recalled.
REQ-023 SHALL never issue an entry with an unready operand, and never issue one entry twice.

Reset
REQ-024 SHALL, while reset = 0, asynchronously clear all valid bits and set occupancy = 0 and mul_valid = 0.
REQ-025 SHALL hold disp_ready = 0 during reset and 1 from the first cycle after release.
REQ-026 SHALL, if reset is asserted mid-operation, discard all entries including partially woken ones; no residual issue after release.

Configuration
REQ-027 SHALL use macro MUL_RS_CDB_FWD_EN: when defined, a dispatched operand with rdy = 0 and tag == cdb_tag under cdb_valid in the same cycle SHALL be written rdy = 1 with cdb_data.
REQ-028 SHALL, when MUL_RS_CDB_FWD_EN is undefined, deassert disp_ready in any cycle where cdb_valid = 1 and a not-ready dispatched operand tag equals cdb_tag (dispatch stalls one cycle; no lost wakeup).

Verification
REQ-029 SHALL cover: dispatch tag 3, src1 = 7, src2 = 6, both ready, mul_ready = 1 -> mul_valid next cycle with multiplier 7, multiplicand 6, iss_rob_tag 3; occupancy 1 -> 0.
REQ-030 SHALL cover: dispatch tag 4, src1 waiting tag 9; CDB tag 9, data -7 two cycles later -> issue one cycle after CDB with multiplier -7.
REQ-031 SHALL cover: fill 4 entries with mul_ready = 0 -> disp_ready = 0 and occupancy 4; raise mul_ready -> oldest issues first, in dispatch order 0,1,2,3.
REQ-032 SHALL cover: entry A (older, waiting) and entry B (ready) -> B issues; after A wakes, A issues next, with no duplicate issue.
REQ-033 SHALL cover: flush with 3 entries and simultaneous disp_valid -> occupancy 0 next cycle, mul_valid = 0, nothing issues afterwards.
REQ-034 SHALL cover: dispatch with src2 tag 5 while CDB broadcasts tag 5 -> with MUL_RS_CDB_FWD_EN the entry captures the data and issues; without it disp_ready = 0 that cycle, and the retry next cycle succeeds.
